// File: rtl/ccff_config_loader.sv
// ----------------------------------------------------------------------------
// ccff_config_loader
//
// Configuration sequencer for the IO tile chain. Bitstream words arrive over a
// valid/ready stream, are serialised LSB-first onto the configuration
// flip-flop chain (ccff_head), and the chain's shift clock is gated with
// ccff_clk_en. Every IO is held isolated (io_isol_n = 0) from reset until the
// whole chain is loaded and a settle delay has elapsed.
//
// Parameters:
//   CHAIN_LEN   - total configuration bits in the chain (>= 1)
//   WORD_W      - input word width (>= 2)
//   RELEASE_DLY - cycles between the last shifted bit and isolation release (>= 1)
//
// Ports:
//   prog_clk    in  : single clock, all state updates on its rising edge
//   prog_reset  in  : synchronous active-high reset
//   start       in  : begin a load (honoured in IDLE or DONE only)
//   abort       in  : cancel the load in progress (SHIFT or SETTLE only)
//   in_data     in  : bitstream word, LSB shifted first
//   in_valid    in  : in_data is valid
//   in_ready    out : word accepted on a cycle with in_valid & in_ready
//   ccff_head   out : serial bit into the chain
//   ccff_clk_en out : chain samples ccff_head at the end of cycles where 1
//   io_isol_n   out : drives IO_ISOL_N, 0 = isolated
//   busy        out : load in progress (SHIFT or SETTLE)
//   done        out : chain loaded and isolation released
//
// All outputs are decoded from registered state; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module ccff_config_loader #(
  parameter int unsigned CHAIN_LEN   = 160,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  output logic              io_isol_n,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BC_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WL_W = $clog2(WORD_W + 1);
  localparam int unsigned DC_W = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [BC_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [WL_W-1:0]   word_left_reg, word_left_next;
  logic [WORD_W-1:0] shreg_reg, shreg_next;
  logic [DC_W-1:0]   dly_cnt_reg, dly_cnt_next;

  logic in_shift;
  logic shifting;
  logic last_bit;
  logic ready_int;
  logic accept;

  // ---------------------------------------------------------------------------
  // Decodes of registered state
  // ---------------------------------------------------------------------------
  assign in_shift = (state_reg == ST_SHIFT);
  assign shifting = in_shift && (word_left_reg != '0);

  // The bit currently on ccff_head is the final chain bit.
  assign last_bit = (32'(bit_cnt_reg) + 32'd1 == 32'(CHAIN_LEN));

  // Ask for a new word while the current one is on its last bit (or empty),
  // but only if the chain still needs bits beyond what is already buffered.
  // This keeps ccff_clk_en gap-free with in_valid held and stops accepting
  // once the final word of the load is in the shift register.
  assign ready_int = in_shift && (word_left_reg <= WL_W'(1)) &&
                     ((32'(bit_cnt_reg) + 32'(word_left_reg)) < 32'(CHAIN_LEN));

  // An abort on the same cycle wins over the handshake.
  assign accept = ready_int && in_valid && !abort;

  assign in_ready    = ready_int;
  assign ccff_clk_en = shifting;
  assign ccff_head   = shifting ? shreg_reg[0] : 1'b0;
  assign busy        = in_shift || (state_reg == ST_SETTLE);
  assign done        = (state_reg == ST_DONE);
  assign io_isol_n   = (state_reg == ST_DONE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      word_left_reg <= '0;
      shreg_reg     <= '0;
      dly_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      word_left_reg <= word_left_next;
      shreg_reg     <= shreg_next;
      dly_cnt_reg   <= dly_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    word_left_next = word_left_reg;
    shreg_next     = shreg_reg;
    dly_cnt_next   = dly_cnt_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next     = ST_SHIFT;
          bit_cnt_next   = '0;
          word_left_next = '0;
        end
      end

      ST_SHIFT: begin
        if (abort) begin
          state_next     = ST_IDLE;
          word_left_next = '0;
        end else begin
          if (shifting) begin
            shreg_next     = shreg_reg >> 1;
            word_left_next = word_left_reg - WL_W'(1);
            bit_cnt_next   = bit_cnt_reg + BC_W'(1);
            if (last_bit) begin
              // Unshifted bits of the final word are simply dropped.
              state_next     = ST_SETTLE;
              word_left_next = '0;
              dly_cnt_next   = '0;
            end
          end
          // ready_int excludes the final-bit cycle, so a load here never
          // collides with the SETTLE transition above.
          if (accept) begin
            shreg_next     = in_data;
            word_left_next = WL_W'(WORD_W);
          end
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (32'(dly_cnt_reg) == RELEASE_DLY - 1) begin
          state_next = ST_DONE;
        end else begin
          dly_cnt_next = dly_cnt_reg + DC_W'(1);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ccff_config_loader.sv
module tb_ccff_config_loader;

  localparam int CL = 40;
  localparam int WW = 32;
  localparam int RD = 4;

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          start;
  logic          abort;
  logic [WW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ccff_head;
  logic          ccff_clk_en;
  logic          io_isol_n;
  logic          busy;
  logic          done;

  ccff_config_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .RELEASE_DLY(RD)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ccff_head  (ccff_head),
    .ccff_clk_en(ccff_clk_en),
    .io_isol_n  (io_isol_n),
    .busy       (busy),
    .done       (done)
  );

  always #5 prog_clk = ~prog_clk;

  int   checks   = 0;
  int   failures = 0;
  bit   exp_q[$];
  int   cyc      = 0;
  int   en_count = 0;
  int   first_en = -1;
  int   last_en  = 0;
  int   pushed   = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected serial bit on every enabled chain cycle and
  // checks isolation release timing against the last shifted bit.
  always @(negedge prog_clk) begin
    cyc++;
    if (ccff_clk_en === 1'b1) begin
      en_count++;
      if (first_en < 0) first_en = cyc;
      last_en = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit actual=%0b required=none cycle=%0d", ccff_head, cyc);
      end else begin
        check("ccff_head", 32'(ccff_head), 32'(exp_q.pop_front()));
      end
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      check("done_latency", 32'(cyc - last_en), 32'(RD + 1));
      check("isol_at_done", 32'(io_isol_n), 32'd1);
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    $display("txn %s: reset-state outputs", tag);
    check({tag, "_in_ready"},    32'(in_ready),    32'd0);
    check({tag, "_ccff_head"},   32'(ccff_head),   32'd0);
    check({tag, "_ccff_clk_en"}, 32'(ccff_clk_en), 32'd0);
    check({tag, "_io_isol_n"},   32'(io_isol_n),   32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
  endtask

  // Issue start and check the first SHIFT cycle.
  task automatic begin_load(input string tag);
    exp_q.delete();
    first_en = -1;
    en_count = 0;
    pushed   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("txn %s: start", tag);
    check({tag, "_start_busy"},  32'(busy),      32'd1);
    check({tag, "_start_ready"}, 32'(in_ready),  32'd1);
    check({tag, "_start_isol"},  32'(io_isol_n), 32'd0);
    check({tag, "_start_done"},  32'(done),      32'd0);
  endtask

  // Offer a word until accepted; on accept push the chain bits it contributes.
  task automatic send_word(input logic [WW-1:0] data);
    logic accepted;
    int   n;
    accepted = 1'b0;
    in_data  = data;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge prog_clk);
      if (in_ready === 1'b1) accepted = 1'b1;
      tick();
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("FAIL word_accept_timeout actual=not_accepted required=accepted data=%08h", data);
    end else begin
      n = CL - pushed;
      if (n > WW) n = WW;
      for (int k = 0; k < n; k++) exp_q.push_back(data[k]);
      pushed += n;
      $display("txn word %08h accepted, %0d chain bits expected", data, n);
    end
  endtask

  task automatic wait_done(input string tag, input int span);
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
    $display("txn %s: load complete en=%0d span=%0d", tag, en_count, last_en - first_en + 1);
    check({tag, "_done"},       32'(done),                  32'd1);
    check({tag, "_isol_n"},     32'(io_isol_n),             32'd1);
    check({tag, "_busy"},       32'(busy),                  32'd0);
    check({tag, "_en_count"},   32'(en_count),              32'(CL));
    check({tag, "_en_span"},    32'(last_en - first_en + 1), 32'(span));
    check({tag, "_bits_left"},  32'(exp_q.size()),          32'd0);
  endtask

  initial begin
    logic saw_done;
    prog_reset = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    tick();
    tick();
    prog_reset = 1'b0;
    check_reset_outputs("reset");

    // Normal load, words always valid.
    begin_load("normal");
    send_word(32'hA5A5A5A5);
    send_word(32'h000000C3);
    in_valid = 1'b0;
    wait_done("normal", CL);

    // Starvation: 5-cycle gap between words (also a start from DONE).
    begin_load("starve");
    send_word(32'hA5A5A5A5);
    in_valid = 1'b0;
    repeat (36) tick();
    send_word(32'h000000C3);
    in_valid = 1'b0;
    wait_done("starve", CL + 5);

    // Abort after 10 shifted bits.
    begin_load("abort");
    send_word(32'h12345678);
    in_valid = 1'b0;
    repeat (9) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("txn abort: after %0d bits", en_count);
    check("abort_bits",        32'(en_count),    32'd10);
    check("abort_busy",        32'(busy),        32'd0);
    check("abort_ccff_clk_en", 32'(ccff_clk_en), 32'd0);
    check("abort_io_isol_n",   32'(io_isol_n),   32'd0);
    check("abort_done",        32'(done),        32'd0);
    check("abort_in_ready",    32'(in_ready),    32'd0);
    exp_q.delete();
    repeat (8) tick();
    check("abort_idle_done", 32'(done), 32'd0);
    begin_load("reload");
    send_word(32'hA5A5A5A5);
    send_word(32'h000000C3);
    in_valid = 1'b0;
    wait_done("reload", CL);

    // Start during SHIFT is ignored.
    begin_load("ignstart");
    send_word(32'hA5A5A5A5);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    send_word(32'h000000C3);
    in_valid = 1'b0;
    wait_done("ignstart", CL);

    // Reset during SETTLE.
    begin_load("midrst");
    send_word(32'hA5A5A5A5);
    send_word(32'h000000C3);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    tick();
    check("midrst_settle_busy", 32'(busy), 32'd1);
    prog_reset = 1'b1;
    tick();
    prog_reset = 1'b0;
    check_reset_outputs("midrst");
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
